// File: rtl/int_ctrl.sv
// Priority interrupt controller: edge-latched pending bits, lowest index wins, one request outstanding at a time.
// Request rises the edge after pending is visible; the request is held until int_ack, and the serviced source is held until int_done.
module int_ctrl #(
   parameter int NUM_SRC    = 4,
   parameter int ADDR_W     = 32,
   parameter int VEC_BASE   = 4,
   parameter int VEC_STRIDE = 4,
   parameter int ID_W       = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [NUM_SRC-1:0] en_mask,
   input  logic               cpu_iflag,
   input  logic               tick_zero,
   output logic               int_req,
   output logic [ADDR_W-1:0]  int_vec,
   output logic [ID_W-1:0]    int_id,
   input  logic               int_ack,
   input  logic               int_done,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [ID_W-1:0]    winner;
   logic [ADDR_W-1:0]  win_vec;
   logic               dispatch;

   always_comb begin
      rise = irq_in & ~prev;
      cand = pending & en_mask;
      dispatch = (|cand) && !cpu_iflag && tick_zero;
   end

   // Scan downward so the lowest-numbered candidate is the last one written.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand[i]) winner = ID_W'(i);
      end
   end

   assign win_vec = ADDR_W'(VEC_BASE) + ADDR_W'(winner) * ADDR_W'(VEC_STRIDE);

   // Clear is applied before the set so a new edge on the acked source survives.
   always_comb begin
      pend_nxt = pending;
      if (state == REQ && int_ack) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (int_id == ID_W'(i)) pend_nxt[i] = 1'b0;
         end
      end
      pend_nxt = pend_nxt | rise;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         prev    <= '0;
         pending <= '0;
         int_req <= 1'b0;
         int_vec <= '0;
         int_id  <= '0;
         busy    <= 1'b0;
      end else begin
         prev    <= irq_in;
         pending <= pend_nxt;
         case (state)
            IDLE: begin
               if (dispatch) begin
                  state   <= REQ;
                  int_req <= 1'b1;
                  busy    <= 1'b1;
                  int_id  <= winner;
                  int_vec <= win_vec;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state   <= SERV;
                  int_req <= 1'b0;
               end
            end
            SERV: begin
               if (int_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               int_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle-by-cycle vector table plus hand-written reset sequences.
module tb_int_ctrl;

   logic        clock;
   logic        reset;
   logic [3:0]  irq_in;
   logic [3:0]  en_mask;
   logic        cpu_iflag;
   logic        tick_zero;
   logic        int_req;
   logic [31:0] int_vec;
   logic [3:0]  int_id;
   logic        int_ack;
   logic        int_done;
   logic [3:0]  pending;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .irq_in    (irq_in),
      .en_mask   (en_mask),
      .cpu_iflag (cpu_iflag),
      .tick_zero (tick_zero),
      .int_req   (int_req),
      .int_vec   (int_vec),
      .int_id    (int_id),
      .int_ack   (int_ack),
      .int_done  (int_done),
      .pending   (pending),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  irq;
      logic [3:0]  en;
      logic        ifl;
      logic        tz;
      logic        ack;
      logic        done;
      logic        req;
      logic [31:0] vec;
      logic [3:0]  id;
      logic [3:0]  pend;
      logic        bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int irq, int en, int ifl, int tz, int ack, int done,
                               int req, int vec, int id, int pend, int bsy);
      vec_t r;
      r.irq  = 4'(irq);
      r.en   = 4'(en);
      r.ifl  = 1'(ifl);
      r.tz   = 1'(tz);
      r.ack  = 1'(ack);
      r.done = 1'(done);
      r.req  = 1'(req);
      r.vec  = 32'(vec);
      r.id   = 4'(id);
      r.pend = 4'(pend);
      r.bsy  = 1'(bsy);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic req, input logic [31:0] vec,
                            input logic [3:0] id, input logic [3:0] pend, input logic bsy);
      check({tag, " int_req"}, 32'(int_req), 32'(req));
      check({tag, " int_vec"}, int_vec, vec);
      check({tag, " int_id"},  32'(int_id), 32'(id));
      check({tag, " pending"}, 32'(pending), 32'(pend));
      check({tag, " busy"},    32'(busy), 32'(bsy));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Fields: irq en ifl tz ack done | req vec id pend busy (state after the edge)
      tbl.push_back(mk(0, 15, 0, 1, 0, 0,  0,  0, 0, 0, 0));
      // single source 1 -> vector 8
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  0,  0, 0, 2, 0));
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  1,  8, 1, 2, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0,  8, 1, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 0,  0,  8, 1, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 1,  0,  8, 1, 0, 0));
      // sources 3 and 0 together: 0 first, then 3
      tbl.push_back(mk(9, 15, 0, 1, 0, 0,  0,  8, 1, 9, 0));
      tbl.push_back(mk(9, 15, 0, 1, 0, 0,  1,  4, 0, 9, 1));
      tbl.push_back(mk(9, 15, 0, 1, 1, 0,  0,  4, 0, 8, 1));
      tbl.push_back(mk(9, 15, 0, 1, 0, 1,  0,  4, 0, 8, 0));
      tbl.push_back(mk(0, 15, 0, 1, 0, 0,  1, 16, 3, 8, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0, 16, 3, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 1,  0, 16, 3, 0, 0));
      // masked source 2 latches but waits for its enable
      tbl.push_back(mk(4, 11, 0, 1, 0, 0,  0, 16, 3, 4, 0));
      tbl.push_back(mk(4, 11, 0, 1, 0, 0,  0, 16, 3, 4, 0));
      tbl.push_back(mk(4, 15, 0, 1, 0, 0,  1, 12, 2, 4, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0, 12, 2, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 1,  0, 12, 2, 0, 0));
      // iflag / tick_zero gating, then request held against mask and iflag
      tbl.push_back(mk(1, 15, 1, 1, 0, 0,  0, 12, 2, 1, 0));
      tbl.push_back(mk(1, 15, 1, 1, 0, 0,  0, 12, 2, 1, 0));
      tbl.push_back(mk(1, 15, 0, 0, 0, 0,  0, 12, 2, 1, 0));
      tbl.push_back(mk(1, 15, 0, 1, 0, 0,  1,  4, 0, 1, 1));
      tbl.push_back(mk(1,  0, 1, 0, 0, 0,  1,  4, 0, 1, 1));
      tbl.push_back(mk(1, 15, 0, 1, 0, 1,  1,  4, 0, 1, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0,  4, 0, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0,  4, 0, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 1,  0,  4, 0, 0, 0));
      tbl.push_back(mk(0, 15, 0, 1, 1, 1,  0,  4, 0, 0, 0));
      // source 1 re-rises on the ack edge and is served again
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  0,  4, 0, 2, 0));
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  1,  8, 1, 2, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 0,  1,  8, 1, 2, 1));
      tbl.push_back(mk(2, 15, 0, 1, 1, 0,  0,  8, 1, 2, 1));
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  0,  8, 1, 2, 1));
      tbl.push_back(mk(2, 15, 0, 1, 0, 1,  0,  8, 1, 2, 0));
      tbl.push_back(mk(2, 15, 0, 1, 0, 0,  1,  8, 1, 2, 1));
      tbl.push_back(mk(0, 15, 0, 1, 1, 0,  0,  8, 1, 0, 1));
      tbl.push_back(mk(0, 15, 0, 1, 0, 1,  0,  8, 1, 0, 0));

      reset = 1'b0; irq_in = '0; en_mask = 4'hF; cpu_iflag = 1'b0; tick_zero = 1'b1;
      int_ack = 1'b0; int_done = 1'b0;
      #2 reset = 1'b1;
      #1 check_all("reset", 1'b0, 32'd0, 4'd0, 4'd0, 1'b0);
      step();
      step();
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         irq_in = tbl[i].irq; en_mask = tbl[i].en; cpu_iflag = tbl[i].ifl;
         tick_zero = tbl[i].tz; int_ack = tbl[i].ack; int_done = tbl[i].done;
         step();
         check_all($sformatf("v%0d", i), tbl[i].req, tbl[i].vec, tbl[i].id, tbl[i].pend, tbl[i].bsy);
      end

      // Abort during SERV with source 3 pending
      irq_in = 4'b0001; int_ack = 1'b0; int_done = 1'b0; en_mask = 4'hF;
      cpu_iflag = 1'b0; tick_zero = 1'b1;
      step();
      step();
      check("abort req", 32'(int_req), 32'd1);
      irq_in = 4'b1001; int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      check("abort pend", 32'(pending), 32'h8);
      check("abort busy", 32'(busy), 32'd1);
      #2 reset = 1'b1; irq_in = '0;
      #1 check_all("async", 1'b0, 32'd0, 4'd0, 4'd0, 1'b0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post req%0d", i), 32'(int_req), 32'd0);
         check($sformatf("post pend%0d", i), 32'(pending), 32'd0);
      end

      // Source high across reset release counts as one rising edge
      irq_in = 4'b0100;
      reset = 1'b1;
      step();
      check("hold pend", 32'(pending), 32'd0);
      reset = 1'b0;
      step();
      check("rel pend", 32'(pending), 32'h4);
      step();
      check_all("rel req", 1'b1, 32'd12, 4'd2, 4'h4, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high, and the ports are named as below.
REQ-002 Parameter NUM_SRC, default 4: number of interrupt sources, legal range 1..16.
REQ-003 Parameter ADDR_W, default 32: width of the vector address.
REQ-004 Parameter VEC_BASE, default 4: vector address of source 0.
REQ-005 Parameter VEC_STRIDE, default 4: address spacing between consecutive vectors.
REQ-006 Parameter ID_W, default 4: width of the source-id output; it must satisfy 2**ID_W >= NUM_SRC.
REQ-007 Port clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-009 Port irq_in, input, NUM_SRC bits: interrupt sources, rising-edge sensitive.
REQ-010 Port en_mask, input, NUM_SRC bits: per-source enable; 1 = may be selected.
REQ-011 Port cpu_iflag, input, 1 bit: CPU status I bit; 1 = CPU already in an interrupt, so no new dispatch.
REQ-012 Port tick_zero, input, 1 bit: CPU is at an instruction boundary (tick == 0).
REQ-013 Port int_req, output, 1 bit: interrupt request to the CPU.
REQ-014 Port int_vec, output, ADDR_W bits: handler address for the requested source.
REQ-015 Port int_id, output, ID_W bits: index of the requested or serviced source.
REQ-016 Port int_ack, input, 1 bit: CPU has taken the request (LR <= PC, PC <= int_vec).
REQ-017 Port int_done, input, 1 bit: CPU executed IRET.
REQ-018 Port pending, output, NUM_SRC bits: latched pending bits, unmasked.
REQ-019 Port busy, output, 1 bit: high while the state is REQ or SERV.

Function
REQ-020 Edge detection: prev <= irq_in every cycle; rise = irq_in & ~prev.
REQ-021 pending[i] SHALL be set at the clock edge where rise[i] = 1, whether or not en_mask[i] is set.
REQ-022 Select candidates = pending & en_mask, then take the lowest index as the highest priority.
REQ-023 FSM states SHALL be IDLE, REQ and SERV, encoded in 2 bits.
REQ-024 IDLE -> REQ when candidates != 0, cpu_iflag = 0 and tick_zero = 1; on that edge, latch int_id = winner and int_vec = VEC_BASE + winner*VEC_STRIDE, truncated to ADDR_W.
REQ-025 In REQ, int_req = 1, and int_id and int_vec SHALL be held stable until int_ack is sampled high.
REQ-026 REQ -> SERV on int_ack = 1; on the same edge pending[int_id] is cleared and int_req drops.
REQ-027 SERV -> IDLE on int_done = 1; int_id SHALL hold its value through SERV.
REQ-028 Latency: from irq_in rising before edge k, pending is visible after edge k, int_req is high after edge k+1 (gates permitting), and int_ack at edge j gives int_req low after edge j.
REQ-029 When a rise and a clear hit the same bit on the same edge, the set SHALL win, so the new event stays pending.
REQ-030 Clearing en_mask or raising cpu_iflag while in REQ SHALL NOT withdraw the request.
REQ-031 int_ack in IDLE or SERV, and int_done in IDLE or REQ, SHALL be ignored.
REQ-032 An edge on the serviced source during SERV SHALL re-set its pending bit; it is dispatched after returning to IDLE.
REQ-033 At most one request outstanding; no nesting or preemption.
REQ-034 Default parameters SHALL map sources 0/1/2 to vectors 4/8/12 (GPIO/UART/TIM1) and source 3 to 16.

Reset
REQ-035 On reset assertion, immediately: state = IDLE, pending = 0, prev = 0, int_req = 0, int_vec = 0, int_id = 0, busy = 0.
REQ-036 Reset in REQ or SERV SHALL abort the transaction with no residual pending bits.
REQ-037 A source already high at reset release SHALL register one rising edge on the first clock.

Verification
REQ-038 irq_in = 4'b0010, en_mask = 4'hF, iflag = 0, tick_zero = 1 -> int_req high 2 cycles after the edge, int_vec = 8, int_id = 1; ack -> pending = 0.
REQ-039 Sources 3 and 0 rise on the same cycle -> source 0 served first (vec 4); after int_done, source 3 is served (vec 16).
REQ-040 Source 2 rises with en_mask[2] = 0 -> pending = 4'b0100, no int_req; set en_mask[2] -> request with vec 12.
REQ-041 cpu_iflag = 1 or tick_zero = 0 while candidates exist -> int_req stays 0; release the gate -> int_req next cycle.
REQ-042 Source 1 re-rises on the same edge as int_ack for id 1 -> pending[1] remains 1; it is re-served after int_done.
REQ-043 Assert reset during SERV with pending = 4'b1000 -> all outputs 0 asynchronously, state IDLE, no request after release.
